wbwr2axil_master: RTL

//  Wishbone (pipelined, B4) slave write port to AXI4-lite master write channel triplet (AW/W/B).

---
 rtl/axil_pkg.sv | 22 ++
 rtl/wbwr2axil_master_if.sv | 66 ++++++
 rtl/wbwr2axil_master.sv | 139 +++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : axil_pkg
//  Description : AXI4-lite response codes and the WB-to-AXI-lite bridge state
//                type.  Shared between the write-half and read-half bridges.
//  Revision    : 1.0  initial release
// ============================================================================
package axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } wb2axil_state_t;

endpackage
`default_nettype wire

// File: rtl/wbwr2axil_master_if.sv
`default_nettype none
// ============================================================================
//  Interface   : wbwr2axil_master_if
//  Description : Bundles the Wishbone slave write port and the AXI4-lite
//                AW/W/B master channels of the write bridge.
//                  master : bridge view (drives WB stall/ack/err, AXI AW/W, bready)
//                  slave  : environment view (WB master plus AXI-lite slave)
//  Revision    : 1.0  initial release
// ============================================================================
interface wbwr2axil_master_if #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 28
) ();

  localparam int DW       = C_AXI_DATA_WIDTH;
  localparam int AXI_LSBS = $clog2(DW/8);
  localparam int AW       = C_AXI_ADDR_WIDTH - AXI_LSBS;

  // Wishbone side
  logic                        i_wb_cyc;
  logic                        i_wb_stb;
  logic                        i_wb_we;
  logic [AW-1:0]               i_wb_addr;
  logic [DW-1:0]               i_wb_data;
  logic [DW/8-1:0]             i_wb_sel;
  logic                        o_wb_stall;
  logic                        o_wb_ack;
  logic                        o_wb_err;

  // AXI4-lite write channels
  logic                        o_axi_awvalid;
  logic                        i_axi_awready;
  logic [C_AXI_ADDR_WIDTH-1:0] o_axi_awaddr;
  logic [2:0]                  o_axi_awprot;
  logic                        o_axi_wvalid;
  logic                        i_axi_wready;
  logic [DW-1:0]               o_axi_wdata;
  logic [DW/8-1:0]             o_axi_wstrb;
  logic                        i_axi_bvalid;
  logic                        o_axi_bready;
  logic [1:0]                  i_axi_bresp;

  modport master (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_err,
    output o_axi_awvalid, o_axi_awaddr, o_axi_awprot,
    input  i_axi_awready,
    output o_axi_wvalid, o_axi_wdata, o_axi_wstrb,
    input  i_axi_wready,
    input  i_axi_bvalid, i_axi_bresp,
    output o_axi_bready
  );

  modport slave (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_err,
    input  o_axi_awvalid, o_axi_awaddr, o_axi_awprot,
    output i_axi_awready,
    input  o_axi_wvalid, o_axi_wdata, o_axi_wstrb,
    output i_axi_wready,
    output i_axi_bvalid, i_axi_bresp,
    input  o_axi_bready
  );

endinterface
`default_nettype wire

// File: rtl/wbwr2axil_master.sv
`default_nettype none
// ============================================================================
//  Module      : wbwr2axil_master
//  Description : Pipelined Wishbone (B4) slave write port to AXI4-lite master
//                write channels (AW/W/B).  Up to 2**LGFIFO writes may await
//                their B response.  Read strobes are never forwarded; they
//                are answered with a bus error once the bridge is idle.
//  Ports       : i_clk    clock
//                w_reset  synchronous, active-high reset
//                bus      wbwr2axil_master_if.master (WB slave + AXI-lite master)
//  Revision    : 1.0  initial release
// ============================================================================
module wbwr2axil_master
  import axil_pkg::*;
#(
  parameter int         C_AXI_DATA_WIDTH = 32,
  parameter int         C_AXI_ADDR_WIDTH = 28,
  parameter int         LGFIFO           = 3,
  parameter logic [2:0] OPT_PROT         = 3'b000
) (
  input  wire logic          i_clk,
  input  wire logic          w_reset,
  wbwr2axil_master_if.master bus
);

  localparam int DW       = C_AXI_DATA_WIDTH;
  localparam int AXI_LSBS = $clog2(DW/8);
  localparam logic [LGFIFO:0] C_FULL_COUNT = {1'b1, {LGFIFO{1'b0}}};

  wb2axil_state_t r_state, w_state_nxt;

  logic                        r_awvalid, r_wvalid;
  logic                        r_ack, r_err;
  logic                        w_ack_nxt, w_err_nxt;
  logic [C_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [DW-1:0]               r_wdata;
  logic [DW/8-1:0]             r_wstrb;
  logic [LGFIFO:0]             r_count;

  logic w_full, w_pending, w_stall;
  logic w_wr_accept, w_rd_accept, w_b_take;

  assign w_full    = (r_count == C_FULL_COUNT);
  assign w_pending = r_awvalid || r_wvalid;

  // Writes keep streaming while ACTIVE; only FLUSH blocks them.  A read has
  // to wait until every write has drained so its error cannot overtake an ack.
  assign w_stall = (r_awvalid && !bus.i_axi_awready)
                || (r_wvalid  && !bus.i_axi_wready)
                || w_full
                || (r_state == FLUSH)
                || (bus.i_wb_stb && !bus.i_wb_we && (r_state != IDLE));

  assign w_wr_accept = bus.i_wb_cyc && bus.i_wb_stb &&  bus.i_wb_we && !w_stall;
  assign w_rd_accept = bus.i_wb_cyc && bus.i_wb_stb && !bus.i_wb_we && !w_stall;

  // A B beat with nothing outstanding is a slave protocol violation: ignore it.
  assign w_b_take = bus.i_axi_bvalid && (r_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = w_rd_accept;
    case (r_state)
      IDLE: begin
        if (w_wr_accept) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!bus.i_wb_cyc) begin
          w_state_nxt = FLUSH;
        end else if (w_b_take) begin
          case (bus.i_axi_bresp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY: w_ack_nxt = 1'b1;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: begin
              w_err_nxt   = 1'b1;
              w_state_nxt = FLUSH;
            end
          endcase
        end else if ((r_count == '0) && !w_pending && !w_wr_accept) begin
          w_state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if ((r_count == '0) && !w_pending) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_reset) begin
      r_state   <= IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;

      if (w_wr_accept)            r_awvalid <= 1'b1;
      else if (bus.i_axi_awready) r_awvalid <= 1'b0;

      if (w_wr_accept)           r_wvalid <= 1'b1;
      else if (bus.i_axi_wready) r_wvalid <= 1'b0;

      case ({w_wr_accept, w_b_take})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload only loads on accept, which the stall term blocks while either
  // channel is still waiting, so AW/W stay stable while valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_accept) begin
      r_awaddr <= {bus.i_wb_addr, {AXI_LSBS{1'b0}}};
      r_wdata  <= bus.i_wb_data;
      r_wstrb  <= bus.i_wb_sel;
    end
  end

  assign bus.o_wb_stall    = w_stall;
  assign bus.o_wb_ack      = r_ack;
  assign bus.o_wb_err      = r_err;
  assign bus.o_axi_awvalid = r_awvalid;
  assign bus.o_axi_awaddr  = r_awaddr;
  assign bus.o_axi_awprot  = OPT_PROT;
  assign bus.o_axi_wvalid  = r_wvalid;
  assign bus.o_axi_wdata   = r_wdata;
  assign bus.o_axi_wstrb   = r_wstrb;
  assign bus.o_axi_bready  = 1'b1;

endmodule
`default_nettype wire
